term_counter: RTL
=================

TERM_COUNTER -- requirements
Module: term_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and compare width in bits (legal range 2..32).
REQ-002 SHALL have parameter RST_VAL, default 0, reset value of the count and the reload register.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port asyn_rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1, count qualifier, one step per clk edge while high in RUN.
REQ-006 SHALL have port load, input, 1, load data_in into the count and the reload register.
REQ-007 SHALL have port data_in, input, WIDTH, load/reload value.
REQ-008 SHALL have port terminal, input, WIDTH, terminal-count compare value.
REQ-009 SHALL have port start, input, 1, IDLE/DONE to RUN request.
REQ-010 SHALL have port stop, input, 1, abort to IDLE.
REQ-011 SHALL have port oneshot, input, 1, mode select: 1 = stop at terminal, 0 = periodic auto-reload.
REQ-012 SHALL have port dir, input, 1, count direction: 0 = up, 1 = down; present only under the macro in REQ-032.
REQ-013 SHALL have port out, output, WIDTH, current count.
REQ-014 SHALL have port tc, output, 1, registered one-cycle terminal-count pulse.
REQ-015 SHALL have port busy, output, 1, high while in RUN.
REQ-016 SHALL have port done, output, 1, high while in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded directly from state.
REQ-018 SHALL make transitions IDLE->RUN on start, DONE->RUN on start, RUN->IDLE on stop, and RUN->DONE on terminal hit with oneshot=1; all other cases hold state.
REQ-019 SHALL give stop priority over start when both are high in the same cycle; the state goes to or stays in IDLE.
REQ-020 SHALL, on load=1 in any state, set count and the reload register to data_in at the next edge; load has priority over counting, and tc SHALL stay 0 for that edge.
REQ-021 SHALL define a terminal hit as state==RUN, enable=1, load=0 and count==terminal, all sampled at the same edge.
REQ-022 SHALL, on a terminal hit, assert tc for exactly the following cycle, and then either reload count from the reload register (oneshot=0, stay in RUN) or hold count (oneshot=1, go to DONE).
REQ-023 SHALL, in RUN with enable=1, load=0 and no terminal hit, step the count by 1 modulo 2^WIDTH in the current direction; wrap 2^WIDTH-1->0 (up) and 0->2^WIDTH-1 (down) SHALL NOT assert tc.
REQ-024 SHALL hold count when enable=0, or when in IDLE or DONE with load=0.
REQ-025 SHALL drive tc=0 in every cycle that does not follow a terminal hit; back-to-back hits (for example terminal==reload) SHALL give tc high on consecutive cycles.
REQ-026 SHALL NOT change count on entry to RUN; the first step occurs on the first RUN-state edge with enable=1.
REQ-027 SHALL evaluate oneshot and dir at each counting edge, so a mid-run change takes effect at the next step.

Reset
REQ-028 SHALL, on asyn_rst high, immediately set count=RST_VAL, reload register=RST_VAL, state=IDLE, tc=0, busy=0, done=0, independent of clk.
REQ-029 SHALL abandon any RUN or DONE operation on reset mid-operation, with no tc pulse generated on release.
REQ-030 SHALL, from the first rising clk edge after asyn_rst deasserts, operate normally.

Configuration
REQ-031 SHALL provide exactly one compile-time option, macro TERM_COUNTER_UPDOWN_EN.
REQ-032 SHALL, with TERM_COUNTER_UPDOWN_EN defined, include the dir port and support up/down counting per REQ-023; without it, omit the dir port and count up only, with all other behaviour identical.

Verification
REQ-033 SHALL cover WIDTH=8: load data_in=8'hFD, terminal=8'h02, oneshot=0, start, enable=1 -> out FD,FE,FF,00,01,02,FD; tc high only in the cycle after the 02 step edge; no tc at FF->00.
REQ-034 SHALL cover oneshot=1, load 0, terminal=3, enable=1 -> out 0,1,2,3 held; one tc pulse; done=1 and busy=0 until the next start.
REQ-035 SHALL cover load=1 together with a terminal hit (count==terminal, enable=1, data_in=8'h10) -> out=8'h10 next cycle, tc=0, state stays RUN.
REQ-036 SHALL cover start and stop high together in IDLE, then in RUN -> state IDLE in both cases, count unchanged, busy=0.
REQ-037 SHALL cover asyn_rst pulsed mid-RUN between clk edges (count=8'h40) -> out=RST_VAL and busy=0 immediately; no tc after release.
REQ-038 SHALL cover, with TERM_COUNTER_UPDOWN_EN, dir=1, load 8'h01, terminal=8'hFE -> out 01,00,FF,FE; tc high after the FE step edge.

Source files
------------

// File: rtl/term_counter.sv
// -----------------------------------------------------------------------------
// term_counter
// Loadable terminal-count counter. It has three operating states:
//   IDLE : the counter is stopped. Only a load changes the count.
//   RUN  : each enabled clock edge steps the count by one.
//   DONE : a one-shot run has reached its terminal value; the count is held.
//
// When the count equals `terminal` on an enabled RUN edge:
//   - tc pulses high for one cycle;
//   - periodic mode (oneshot=0) reloads the count from the reload register;
//   - one-shot mode (oneshot=1) holds the count and moves to DONE.
//
// Compile-time option:
//   TERM_COUNTER_UPDOWN_EN - adds the `dir` port (0 = up, 1 = down).
//                            Without it, the counter counts up only.
//
// Parameters:
//   WIDTH   - counter and compare width in bits (2..32)
//   RST_VAL - reset value of the count and of the reload register
//
// Ports:
//   clk      - rising-edge clock
//   asyn_rst - asynchronous active-high reset
//   enable   - count qualifier; one step per edge while high in RUN
//   load     - load data_in into the count and the reload register
//              (priority over counting)
//   data_in  - load/reload value
//   terminal - terminal-count compare value
//   start    - IDLE/DONE -> RUN request
//   stop     - abort to IDLE (priority over start)
//   oneshot  - 1 = stop at terminal, 0 = periodic auto-reload
//   dir      - 0 = up, 1 = down (only with TERM_COUNTER_UPDOWN_EN)
//   out      - current count
//   tc       - registered one-cycle terminal-count pulse
//   busy     - high while in RUN
//   done     - high while in DONE
// -----------------------------------------------------------------------------
module term_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             asyn_rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] terminal,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
`ifdef TERM_COUNTER_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    logic [1:0]       w_state_nxt;
    logic             w_run;
    logic             w_hit;
    logic             w_down;

    // Step by one modulo 2^WIDTH. Wrap-around is an ordinary step, not a terminal event.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v, input logic down);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (down) begin
            f_step = v - one;
        end else begin
            f_step = v + one;
        end
    endfunction

`ifdef TERM_COUNTER_UPDOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    assign w_run = (r_state == ST_RUN);
    // A load on the same edge suppresses the hit, so a load edge never pulses tc.
    assign w_hit = w_run & enable & ~load & (r_count == terminal);

    // Next-state selection. Stop beats start in every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit && oneshot) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start && stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, count, reload register and terminal pulse.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            r_state  <= ST_IDLE;
            r_count  <= RST_VAL;
            r_reload <= RST_VAL;
            r_tc     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_hit;
            if (load) begin
                r_count  <= data_in;
                r_reload <= data_in;
            end else if (w_hit) begin
                // One-shot keeps the terminal value on display; periodic reloads.
                if (!oneshot) begin
                    r_count <= r_reload;
                end else begin
                    r_count <= r_count;
                end
            end else if (w_run && enable) begin
                r_count <= f_step(r_count, w_down);
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign out  = r_count;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
